// File: rtl/ladder_pkg.sv
// Shared types and constants for the scalar sequencer and its scan helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ladder_pkg;

  // Default scalar width used by the ladder datapath.
  localparam int K_WIDTH_DFLT = 256;

  // Sequencer control states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    START = 3'd2,
    FEED  = 3'd3,
    WAIT  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/ladder_msb_scan.sv
// Holds the latched scalar K, the bit-index down-counter and the zero detect.
// Latency: load/step take effect on the next sys_clk edge; cur_bit/found/zero are combinational from state.
// Backpressure: none; the owning FSM decides when to load and step.
module ladder_msb_scan
  import ladder_pkg::*;
#(
  parameter int K_WIDTH = K_WIDTH_DFLT,
  parameter int IDX_W   = $clog2(K_WIDTH)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               load,
  input  logic [K_WIDTH-1:0] load_k,
  input  logic               step,
  output logic               found,
  output logic               zero,
  output logic               idx_zero,
  output logic               cur_bit
);

  logic [K_WIDTH-1:0] k_q;
  logic [IDX_W-1:0]   idx_q;

  // Latch K on accept and walk the index down from the MSB; never wraps below 0.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      k_q   <= '0;
      idx_q <= '0;
    end else if (load) begin
      k_q   <= load_k;
      idx_q <= IDX_W'(K_WIDTH - 1);
    end else if (step && (idx_q != '0)) begin
      idx_q <= idx_q - 1'b1;
    end
  end

  // Bit under the index, and the scan results derived from it.
  always_comb begin
    cur_bit  = k_q[idx_q];
    idx_zero = (idx_q == '0);
    found    = cur_bit;
    zero     = idx_zero && !cur_bit;
  end

endmodule

// File: rtl/ladder_scalar_sequencer.sv
// Runs one Montgomery-ladder job: finds the MSB of K, starts the ladder, serves bits MSB-first, reports done/error.
// Latency: accept->lad_start (K_WIDTH-1-msb)+2 cycles; k_req->k_val 1 cycle; lad_ready->done 1 cycle.
// Backpressure: cmd_ready only in IDLE (commands are not queued); bits are sent only when the ladder requests them.
module ladder_scalar_sequencer
  import ladder_pkg::*;
#(
  parameter int K_WIDTH = K_WIDTH_DFLT,
  parameter int IDX_W   = $clog2(K_WIDTH)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [K_WIDTH-1:0] cmd_k,
  output logic               lad_start,
  input  logic               lad_ready,
  input  logic               k_req,
  output logic               k_val,
  output logic               k_bit,
  output logic               k_last,
  output logic               busy,
  output logic               done,
  output logic               err_zero,
  output logic               err_proto,
  output logic [IDX_W:0]     bits_sent
);

  localparam logic [IDX_W:0] BITS_MAX = (IDX_W+1)'(K_WIDTH);

  seq_state_t state;
  logic       scan_load;
  logic       scan_step;
  logic       scan_found;
  logic       scan_zero;
  logic       scan_idx_zero;
  logic       scan_cur_bit;
  logic       last_beat;

  ladder_msb_scan #(
    .K_WIDTH (K_WIDTH),
    .IDX_W   (IDX_W)
  ) u_scan (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (scan_load),
    .load_k   (cmd_k),
    .step     (scan_step),
    .found    (scan_found),
    .zero     (scan_zero),
    .idx_zero (scan_idx_zero),
    .cur_bit  (scan_cur_bit)
  );

  // Scan control: load on accept, step while searching and after each delivered bit.
  always_comb begin
    last_beat = k_val && scan_idx_zero;
    scan_load = (state == IDLE) && cmd_valid;
    scan_step = ((state == SCAN) && !scan_found) ||
                ((state == FEED) && k_val);
  end

  // Status and bit outputs decoded from registered state; k_bit is forced low outside FEED.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    k_bit     = (state == FEED) && scan_cur_bit;
    k_last    = last_beat;
  end

  // Sequencer FSM with registered strobes; every pulse defaults low each cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      lad_start <= 1'b0;
      k_val     <= 1'b0;
      done      <= 1'b0;
      err_zero  <= 1'b0;
      err_proto <= 1'b0;
      bits_sent <= '0;
    end else begin
      lad_start <= 1'b0;
      k_val     <= 1'b0;
      done      <= 1'b0;
      err_zero  <= 1'b0;
      err_proto <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            bits_sent <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (scan_found) begin
            lad_start <= 1'b1;
            state     <= START;
          end else if (scan_zero) begin
            err_zero <= 1'b1;
            state    <= IDLE;
          end
        end
        START: begin
          if (lad_ready) begin
            err_proto <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= FEED;
          end
        end
        FEED: begin
          if (lad_ready) begin
            err_proto <= 1'b1;
            state     <= IDLE;
          end else if (last_beat) begin
            // A request coinciding with the final beat is dropped.
            state <= WAIT;
          end else if (k_req) begin
            k_val <= 1'b1;
            if (bits_sent != BITS_MAX) begin
              bits_sent <= bits_sent + 1'b1;
            end
          end
        end
        WAIT: begin
          if (lad_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
